l4_array_ctrl: RTL and testbench
================================

# l4_array_ctrl

Host-side sequencer that drives the command inputs of the L4 32x32 routing array (range decoders, cell command, preference and mode bits) and collects the array's `status_out`. It accepts one command at a time over a valid/ready handshake and presents ranges and flags with the correct setup timing for the registered decoders. It issues one array step, or repeats steps until a masked status match or a step limit. It then returns a response word over a second valid/ready handshake. It sits between the PCI register/mailbox logic and the array top level.

## Interface
- `NRBITS`, 5, row index width
- `NCBITS`, 5, column index width
- `NSBITS`, 10, step counter width; step limit = 2^NSBITS-1
- `PIPE`, 2, cycles from `cell_cmd` issue to valid `status_out` (decoder register + array register)

Ports:
- `clk` in 1: single clock, rising edge
- `resetn` in 1: asynchronous, active-low reset
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake
- `cmd_loop` in 1: 1 = repeat until match/limit, 0 = single step
- `cmd_cell_cmd` in 2: array cell command; 2'b00 is NOP
- `cmd_row_sel` in 3, `cmd_row_l` in NRBITS, `cmd_row_u` in NRBITS: row range select, lower bound, upper bound
- `cmd_col_sel` in 3, `cmd_col_l` in NCBITS, `cmd_col_u` in NCBITS: column range select, lower bound, upper bound
- `cmd_flags` in 7: {etch_enb, pref_ud, pref_ns, pref_ew, ret2ue, extend, top_l}
- `cmd_status` in 4: value driven to the array `status_in`
- `cmd_match` in 4, `cmd_mask` in 4: loop termination compare
- `row_range_sel` out 3, `row_l_v`/`row_u_v` out NRBITS, `col_range_sel` out 3, `col_l_v`/`col_u_v` out NCBITS: to decoders
- `cell_cmd` out 2, `status_in` out 4, `etch_enb`, `pref_ud`, `pref_ns`, `pref_ew`, `ret2ue`, `extend`, `top_l` out 1 each: to array
- `status_out` in 4: from array
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake
- `rsp_status` out 4: last sampled `status_out`
- `rsp_steps` out NSBITS: number of steps issued
- `rsp_timeout` out 1: loop ended on the step limit without a match

## Operation
- States: IDLE, SETUP, ISSUE, WAIT, RESP.
- `cmd_ready` = 1 only in IDLE. A command is accepted on an edge with `cmd_valid & cmd_ready`. Accept registers all cmd fields, clears the step counter, and moves to SETUP.
- SETUP, 1 cycle: range, flag and `status_in` outputs take the registered command values. `cell_cmd` = 00. Next state is ISSUE.
- ISSUE, 1 cycle: `cell_cmd` = registered `cmd_cell_cmd`, and the step counter increments. Next state is WAIT.
- WAIT, PIPE cycles, with `cell_cmd` = 00. On the edge ending the last WAIT cycle, `status_out` is captured into `rsp_status`.
  - Match is `(status_out & cmd_mask) == (cmd_match & cmd_mask)`.
  - If `cmd_loop` = 0, or match, the next state is RESP with `rsp_timeout` = 0.
  - Else if the step counter = 2^NSBITS-1, the next state is RESP with `rsp_timeout` = 1.
  - Else the next state is ISSUE.
- `cmd_mask` = 0 always matches, so a looped command runs exactly one step.
- RESP: `rsp_valid` = 1, and all rsp fields are held stable until `rsp_valid & rsp_ready`. The state then returns to IDLE; the handshake edge deasserts `rsp_valid`.
- `cell_cmd` is nonzero only in ISSUE. Range, flag and `status_in` outputs hold their last command values through IDLE until the next accept.
- The step counter never wraps; the limit check precedes the increment.

## Timing
- Reset, asynchronous: state = IDLE. The following are all 0: every array-side output, `rsp_valid`, `rsp_status`, `rsp_steps`, `rsp_timeout` and the step counter. `cmd_ready` = 1 from reset deassertion.
- Reset mid-command: the command is abandoned, `cell_cmd` returns to 00 immediately, and no response is produced.
- Single step: accept edge E. SETUP is cycle E+1 and ISSUE is E+2. `rsp_valid` rises at E+PIPE+2 (E+4 at default). The next `cmd_ready` follows the cycle after the response handshake.
- Looped, N steps: `rsp_valid` rises at E + 1 + N*(1+PIPE).
- `cmd_*` inputs are ignored outside the accept edge. Changes while busy have no effect.
- `rsp_ready` held high in RESP: the response completes in 1 cycle.

## Test plan
- Reset asserted mid-WAIT with `cell_cmd`=10 -> all outputs 0 at once. `cmd_ready`=1 after release, and no `rsp_valid`.
- Single step, rows 3..7 and cols 0..31, `cell_cmd`=01, `cmd_loop`=0 -> ranges visible at E+1. `cell_cmd`=01 only in E+2. `rsp_valid` at E+4 with `rsp_steps`=1 and `rsp_status` = `status_out` sampled at E+4.
- Loop with match=4'b1000 and mask=4'b1000, bench asserting status_out[3] after the 5th step -> `rsp_steps`=5, `rsp_timeout`=0, `rsp_valid` at E+16.
- Loop with no match, NSBITS=3 -> `rsp_steps`=7, `rsp_timeout`=1, 7 ISSUE pulses observed.
- `rsp_ready` held low 10 cycles -> response fields stable, `cmd_ready`=0 throughout. A new `cmd_valid` is accepted only after the handshake.
- `cmd_mask`=0 with `cmd_loop`=1 -> exactly one step; `cmd_*` toggled while busy has no effect on the outputs.

Source files
------------

// File: rtl/l4_array_ctrl.sv
// Host-side sequencer for the L4 32x32 routing array: latches one command, drives the
// decoder/array inputs with setup timing, steps the array and returns a response word.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for a command, cmd_ready high
// S_SETUP | ranges/flags/status_in settle into the registered decoders
// S_ISSUE | cell_cmd driven for one cycle, step counter increments
// S_WAIT  | PIPE cycles until status_out is valid, then match/limit check
// S_RESP  | response held until rsp_ready
module l4_array_ctrl #(
  parameter int NRBITS = 5,
  parameter int NCBITS = 5,
  parameter int NSBITS = 10,
  parameter int PIPE   = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_loop,
  input  logic [1:0]        cmd_cell_cmd,
  input  logic [2:0]        cmd_row_sel,
  input  logic [NRBITS-1:0] cmd_row_l,
  input  logic [NRBITS-1:0] cmd_row_u,
  input  logic [2:0]        cmd_col_sel,
  input  logic [NCBITS-1:0] cmd_col_l,
  input  logic [NCBITS-1:0] cmd_col_u,
  input  logic [6:0]        cmd_flags,
  input  logic [3:0]        cmd_status,
  input  logic [3:0]        cmd_match,
  input  logic [3:0]        cmd_mask,
  output logic [2:0]        row_range_sel,
  output logic [NRBITS-1:0] row_l_v,
  output logic [NRBITS-1:0] row_u_v,
  output logic [2:0]        col_range_sel,
  output logic [NCBITS-1:0] col_l_v,
  output logic [NCBITS-1:0] col_u_v,
  output logic [1:0]        cell_cmd,
  output logic [3:0]        status_in,
  output logic              etch_enb,
  output logic              pref_ud,
  output logic              pref_ns,
  output logic              pref_ew,
  output logic              ret2ue,
  output logic              extend,
  output logic              top_l,
  input  logic [3:0]        status_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [3:0]        rsp_status,
  output logic [NSBITS-1:0] rsp_steps,
  output logic              rsp_timeout
);

  localparam int WW = (PIPE > 1) ? $clog2(PIPE) : 1;
  localparam logic [NSBITS-1:0] STEP_MAX = {NSBITS{1'b1}};

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [NSBITS-1:0]   steps_q, steps_d;
  logic [WW-1:0]       wait_q, wait_d;
  logic [3:0]          rsp_status_q, rsp_status_d;
  logic                rsp_timeout_q, rsp_timeout_d;

  logic                loop_q;
  logic [1:0]          ccmd_q;
  logic [2:0]          row_sel_q, col_sel_q;
  logic [NRBITS-1:0]   row_l_q, row_u_q;
  logic [NCBITS-1:0]   col_l_q, col_u_q;
  logic [6:0]          flags_q;
  logic [3:0]          status_q, match_q, mask_q;

  logic                accept;
  logic                match;

  assign accept = (state_q == S_IDLE) && cmd_valid;
  assign match  = ((status_out ^ match_q) & mask_q) == 4'b0000;

  always_comb begin
    state_d       = state_q;
    steps_d       = steps_q;
    wait_d        = wait_q;
    rsp_status_d  = rsp_status_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_SETUP;
          steps_d = '0;
        end
      end
      S_SETUP: state_d = S_ISSUE;
      S_ISSUE: begin
        steps_d = steps_q + 1'b1;
        wait_d  = WW'(PIPE - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q != '0) begin
          wait_d = wait_q - 1'b1;
        end else begin
          rsp_status_d = status_out;
          if (!loop_q || match) begin
            state_d       = S_RESP;
            rsp_timeout_d = 1'b0;
          end else if (steps_q == STEP_MAX) begin
            // limit reached before another ISSUE, so the counter never wraps
            state_d       = S_RESP;
            rsp_timeout_d = 1'b1;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      steps_q       <= '0;
      wait_q        <= '0;
      rsp_status_q  <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      steps_q       <= steps_d;
      wait_q        <= wait_d;
      rsp_status_q  <= rsp_status_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Command fields only load on accept, so they hold through IDLE until the next command.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      loop_q    <= 1'b0;
      ccmd_q    <= '0;
      row_sel_q <= '0;
      row_l_q   <= '0;
      row_u_q   <= '0;
      col_sel_q <= '0;
      col_l_q   <= '0;
      col_u_q   <= '0;
      flags_q   <= '0;
      status_q  <= '0;
      match_q   <= '0;
      mask_q    <= '0;
    end else if (accept) begin
      loop_q    <= cmd_loop;
      ccmd_q    <= cmd_cell_cmd;
      row_sel_q <= cmd_row_sel;
      row_l_q   <= cmd_row_l;
      row_u_q   <= cmd_row_u;
      col_sel_q <= cmd_col_sel;
      col_l_q   <= cmd_col_l;
      col_u_q   <= cmd_col_u;
      flags_q   <= cmd_flags;
      status_q  <= cmd_status;
      match_q   <= cmd_match;
      mask_q    <= cmd_mask;
    end
  end

  assign cmd_ready     = (state_q == S_IDLE);
  assign cell_cmd      = (state_q == S_ISSUE) ? ccmd_q : 2'b00;
  assign row_range_sel = row_sel_q;
  assign row_l_v       = row_l_q;
  assign row_u_v       = row_u_q;
  assign col_range_sel = col_sel_q;
  assign col_l_v       = col_l_q;
  assign col_u_v       = col_u_q;
  assign status_in     = status_q;
  assign {etch_enb, pref_ud, pref_ns, pref_ew, ret2ue, extend, top_l} = flags_q;
  assign rsp_valid     = (state_q == S_RESP);
  assign rsp_status    = rsp_status_q;
  assign rsp_steps     = steps_q;
  assign rsp_timeout   = rsp_timeout_q;

endmodule

// File: tb/tb_l4_array_ctrl.sv
// Directed bench for l4_array_ctrl with a 3-bit step counter so the step limit is reachable.
module tb_l4_array_ctrl;

  localparam int NRB = 5;
  localparam int NCB = 5;
  localparam int NSB = 3;
  localparam int PIPE = 2;

  logic            clk = 1'b0;
  logic            resetn;
  logic            cmd_valid, cmd_ready, cmd_loop;
  logic [1:0]      cmd_cell_cmd;
  logic [2:0]      cmd_row_sel, cmd_col_sel;
  logic [NRB-1:0]  cmd_row_l, cmd_row_u;
  logic [NCB-1:0]  cmd_col_l, cmd_col_u;
  logic [6:0]      cmd_flags;
  logic [3:0]      cmd_status, cmd_match, cmd_mask;
  logic [2:0]      row_range_sel, col_range_sel;
  logic [NRB-1:0]  row_l_v, row_u_v;
  logic [NCB-1:0]  col_l_v, col_u_v;
  logic [1:0]      cell_cmd;
  logic [3:0]      status_in, status_out, rsp_status;
  logic            etch_enb, pref_ud, pref_ns, pref_ew, ret2ue, extend, top_l;
  logic            rsp_valid, rsp_ready, rsp_timeout;
  logic [NSB-1:0]  rsp_steps;

  int n_chk = 0;
  int n_pass = 0;

  l4_array_ctrl #(.NRBITS(NRB), .NCBITS(NCB), .NSBITS(NSB), .PIPE(PIPE)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_loop(cmd_loop),
    .cmd_cell_cmd(cmd_cell_cmd),
    .cmd_row_sel(cmd_row_sel), .cmd_row_l(cmd_row_l), .cmd_row_u(cmd_row_u),
    .cmd_col_sel(cmd_col_sel), .cmd_col_l(cmd_col_l), .cmd_col_u(cmd_col_u),
    .cmd_flags(cmd_flags), .cmd_status(cmd_status),
    .cmd_match(cmd_match), .cmd_mask(cmd_mask),
    .row_range_sel(row_range_sel), .row_l_v(row_l_v), .row_u_v(row_u_v),
    .col_range_sel(col_range_sel), .col_l_v(col_l_v), .col_u_v(col_u_v),
    .cell_cmd(cell_cmd), .status_in(status_in),
    .etch_enb(etch_enb), .pref_ud(pref_ud), .pref_ns(pref_ns), .pref_ew(pref_ew),
    .ret2ue(ret2ue), .extend(extend), .top_l(top_l),
    .status_out(status_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_steps(rsp_steps), .rsp_timeout(rsp_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic lp, input logic [1:0] cc,
                         input logic [2:0] rs, input logic [4:0] rl, input logic [4:0] ru,
                         input logic [2:0] cs, input logic [4:0] cl, input logic [4:0] cu,
                         input logic [6:0] fl, input logic [3:0] st,
                         input logic [3:0] mt, input logic [3:0] mk);
    cmd_valid = 1'b1; cmd_loop = lp; cmd_cell_cmd = cc;
    cmd_row_sel = rs; cmd_row_l = rl; cmd_row_u = ru;
    cmd_col_sel = cs; cmd_col_l = cl; cmd_col_u = cu;
    cmd_flags = fl; cmd_status = st; cmd_match = mt; cmd_mask = mk;
  endtask

  // Starts in SETUP; counts ISSUE pulses and cycles until rsp_valid, optionally
  // raising status_out after a chosen ISSUE and scrambling cmd_* while busy.
  task automatic run_rsp(input int budget, input int set_after, input logic [3:0] set_val,
                         input bit scramble, output int cycles, output int issues);
    cycles = 0;
    issues = 0;
    while (!rsp_valid && cycles < budget) begin
      if (cell_cmd != 2'b00) begin
        issues++;
        if (issues == set_after) status_out = set_val;
      end
      if (scramble) begin
        cmd_valid = 1'($urandom); cmd_loop = 1'($urandom);
        cmd_cell_cmd = 2'($urandom); cmd_row_l = 5'($urandom); cmd_col_u = 5'($urandom);
        cmd_flags = 7'($urandom); cmd_status = 4'($urandom); cmd_mask = 4'($urandom);
      end
      tick();
      cycles++;
    end
    check("rsp_seen", 32'(rsp_valid), 1);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("hs_rsp_valid_low", 32'(rsp_valid), 0);
    check("hs_cmd_ready", 32'(cmd_ready), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int cyc, iss;
    bit stable, busy_ok, seen;

    resetn = 1'b0; rsp_ready = 1'b0; status_out = 4'h0;
    set_cmd(1'b0, 2'b00, 3'd0, 5'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 4'd0, 4'd0, 4'd0);
    cmd_valid = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_cell_cmd", 32'(cell_cmd), 0);
    check("rst_ranges", 32'({row_range_sel, row_l_v, row_u_v, col_range_sel, col_l_v, col_u_v}), 0);
    check("rst_rsp_fields", 32'({rsp_status, rsp_steps, rsp_timeout}), 0);

    // single step, rows 3..7, cols 0..31
    status_out = 4'h5;
    set_cmd(1'b0, 2'b01, 3'b001, 5'd3, 5'd7, 3'b010, 5'd0, 5'd31, 7'b1010011, 4'hA, 4'h0, 4'hF);
    tick();
    cmd_valid = 1'b0;
    check("ss_setup_rows", 32'({row_range_sel, row_l_v, row_u_v}), 32'({3'b001, 5'd3, 5'd7}));
    check("ss_setup_cols", 32'({col_range_sel, col_l_v, col_u_v}), 32'({3'b010, 5'd0, 5'd31}));
    check("ss_setup_flags", 32'({etch_enb, pref_ud, pref_ns, pref_ew, ret2ue, extend, top_l}), 32'h53);
    check("ss_setup_status_in", 32'(status_in), 32'hA);
    check("ss_setup_cell", 32'(cell_cmd), 0);
    check("ss_setup_cmd_ready", 32'(cmd_ready), 0);
    tick();
    check("ss_issue_cell", 32'(cell_cmd), 1);
    tick();
    check("ss_wait1_cell", 32'(cell_cmd), 0);
    tick();
    check("ss_wait2_cell", 32'(cell_cmd), 0);
    check("ss_wait2_no_rsp", 32'(rsp_valid), 0);
    status_out = 4'h6;
    tick();
    check("ss_rsp_valid_e4", 32'(rsp_valid), 1);
    check("ss_rsp_steps", 32'(rsp_steps), 1);
    check("ss_rsp_status", 32'(rsp_status), 32'h6);
    check("ss_rsp_timeout", 32'(rsp_timeout), 0);
    handshake();
    check("ss_hold_ranges", 32'({row_l_v, row_u_v}), 32'({5'd3, 5'd7}));

    // loop until status_out[3] appears after the 5th step
    status_out = 4'b0010;
    set_cmd(1'b1, 2'b10, 3'b100, 5'd1, 5'd2, 3'b100, 5'd4, 5'd5, 7'd0, 4'h3, 4'b1000, 4'b1000);
    tick();
    cmd_valid = 1'b0;
    run_rsp(60, 5, 4'b1000, 1'b0, cyc, iss);
    check("lm_cycles", 32'(cyc), 16);
    check("lm_issues", 32'(iss), 5);
    check("lm_steps", 32'(rsp_steps), 5);
    check("lm_timeout", 32'(rsp_timeout), 0);
    check("lm_status", 32'(rsp_status), 32'h8);
    handshake();

    // loop without match until the step limit
    status_out = 4'b0000;
    set_cmd(1'b1, 2'b11, 3'b011, 5'd2, 5'd9, 3'b011, 5'd6, 5'd8, 7'h7F, 4'h1, 4'b0001, 4'b0001);
    tick();
    cmd_valid = 1'b0;
    run_rsp(80, 0, 4'h0, 1'b0, cyc, iss);
    check("to_cycles", 32'(cyc), 22);
    check("to_issues", 32'(iss), 7);
    check("to_steps", 32'(rsp_steps), 7);
    check("to_timeout", 32'(rsp_timeout), 1);

    // rsp_ready low 10 cycles with a new command pending
    set_cmd(1'b1, 2'b11, 3'b101, 5'd9, 5'd12, 3'b110, 5'd1, 5'd3, 7'h21, 4'h7, 4'hF, 4'h0);
    stable = 1'b1; busy_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!rsp_valid || rsp_steps != 3'd7 || !rsp_timeout || rsp_status != 4'h0) stable = 1'b0;
      if (cmd_ready || row_l_v != 5'd2) busy_ok = 1'b0;
    end
    check("hold_rsp_stable", 32'(stable), 1);
    check("hold_cmd_ready_low", 32'(busy_ok), 1);
    handshake();
    tick();
    check("post_hs_accept", 32'(cmd_ready), 0);
    check("post_hs_row_l", 32'(row_l_v), 9);

    // mask 0 loop: exactly one step, cmd_* scrambled while busy
    run_rsp(40, 0, 4'h0, 1'b1, cyc, iss);
    cmd_valid = 1'b0;
    check("m0_cycles", 32'(cyc), 4);
    check("m0_issues", 32'(iss), 1);
    check("m0_steps", 32'(rsp_steps), 1);
    check("m0_timeout", 32'(rsp_timeout), 0);
    check("m0_outputs_kept", 32'({row_l_v, col_u_v, status_in}), 32'({5'd9, 5'd3, 4'h7}));
    check("m0_flags_kept", 32'({etch_enb, pref_ud, pref_ns, pref_ew, ret2ue, extend, top_l}), 32'h21);
    handshake();

    // reset during WAIT with cell_cmd = 10
    set_cmd(1'b0, 2'b10, 3'b111, 5'd4, 5'd20, 3'b111, 5'd2, 5'd30, 7'h55, 4'hC, 4'h0, 4'h0);
    tick();
    cmd_valid = 1'b0;
    tick();
    check("rw_issue_cell", 32'(cell_cmd), 2);
    tick();
    resetn = 1'b0;
    #1;
    check("rw_cell_zero", 32'(cell_cmd), 0);
    check("rw_ranges_zero", 32'({row_range_sel, row_l_v, row_u_v, col_range_sel, col_l_v, col_u_v}), 0);
    check("rw_flags_status_zero", 32'({etch_enb, pref_ud, pref_ns, pref_ew, ret2ue, extend, top_l, status_in}), 0);
    check("rw_rsp_zero", 32'({rsp_valid, rsp_status, rsp_steps, rsp_timeout}), 0);
    #1;
    resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    check("rw_no_rsp", 32'(seen), 0);
    check("rw_cmd_ready", 32'(cmd_ready), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
